// File: rtl/apb_gpio_arbiter_pkg.sv
// apb_gpio_arb_pkg: shared FSM states, GPIO register map and timeout counter width for the APB GPIO arbiter
package apb_gpio_arb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} arb_state_e;
    localparam int TO_W = 8;
    localparam logic [11:0] GPIO_PADFUN0   = 12'h000;
    localparam logic [11:0] GPIO_PADFUN1   = 12'h004;
    localparam logic [11:0] GPIO_PADDIR    = 12'h008;
    localparam logic [11:0] GPIO_PADIN     = 12'h00C;
    localparam logic [11:0] GPIO_PADOUT    = 12'h010;
    localparam logic [11:0] GPIO_INTEN     = 12'h014;
    localparam logic [11:0] GPIO_INTTYPE0  = 12'h018;
    localparam logic [11:0] GPIO_INTTYPE1  = 12'h01C;
    localparam logic [11:0] GPIO_INTSTATUS = 12'h020;
endpackage

// File: rtl/apb_gpio_arbiter_if.sv
// apb_gpio_arbiter_if: APB bus between the arbiter (master) and the GPIO slave
interface apb_gpio_arbiter_if #(parameter int APB_ADDR_WIDTH = 12);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic PWRITE;
    logic PSEL;
    logic PENABLE;
    logic PREADY;
    logic PSLVERR;
    modport master (output PADDR, PWDATA, PWRITE, PSEL, PENABLE, input PRDATA, PREADY, PSLVERR);
    modport slave (input PADDR, PWDATA, PWRITE, PSEL, PENABLE, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_gpio_arbiter_rr_arb.sv
// apb_gpio_rr_arb: combinational round-robin pick, first valid requester after ptr with wrap-around
module apb_gpio_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);
    logic [IW-1:0] j;
    // Scan from farthest to nearest so the nearest valid index after ptr wins
    always_comb begin
        grant = '0;
        idx = '0;
        j = '0;
        any = |req_valid;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = IW'((int'(ptr) + k) % NUM_REQ);
            idx = req_valid[j] ? j : idx;
        end
        grant[idx] = any;
    end
endmodule

// File: rtl/apb_gpio_arbiter.sv
// apb_gpio_arbiter: round-robin APB master sharing one GPIO slave; APB_GPIO_ARB_TIMEOUT_EN adds an ACCESS timeout
module apb_gpio_arbiter
    import apb_gpio_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]         req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [31:0]                   rsp_rdata,
    output logic                          rsp_err,
    apb_gpio_arbiter_if.master            apb
);
    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) $error("NUM_REQ must be 2..8");
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) $error("TIMEOUT_CYCLES must be 1..255");

    arb_state_e state, state_nxt;
    logic [IW-1:0] ptr, win_idx;
    logic [NUM_REQ-1:0] grant;
    logic any_req, done, abort;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [31:0] wdata_q;
    logic write_q;

    apb_gpio_rr_arb #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr_arb (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .idx       (win_idx),
        .any       (any_req)
    );

    assign done = state == ACCESS && apb.PREADY;

`ifdef APB_GPIO_ARB_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    // Count stalled ACCESS cycles; cleared while in SETUP so every transfer starts from zero
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) to_cnt <= '0;
        else if (state == SETUP) to_cnt <= '0;
        else if (state == ACCESS && !apb.PREADY) to_cnt <= to_cnt + 1'b1;
    end
    assign abort = state == ACCESS && !apb.PREADY && to_cnt == TO_W'(TIMEOUT_CYCLES - 1);
`else
    assign abort = 1'b0;
`endif

    // State register; PSEL/PENABLE decode from it, so they drop the moment reset asserts
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else state <= state_nxt;
    end

    // Next state and the combinational acceptance pulse
    always_comb begin
        state_nxt = state == IDLE ? (any_req ? SETUP : IDLE) :
                    state == SETUP ? ACCESS :
                    (done || abort) ? IDLE : ACCESS;
        req_ready = state == IDLE ? grant : '0;
    end

    // Latch the winning request; ptr doubles as the owner of the transfer in flight
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ptr <= IW'(NUM_REQ - 1);
            addr_q <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (state == IDLE && any_req) begin
            ptr <= win_idx;
            addr_q <= req_addr[win_idx*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            wdata_q <= req_wdata[win_idx*32 +: 32];
            write_q <= req_write[win_idx];
        end
    end

    // Register the response; rdata is zero for writes and timeouts, data/err hold until the next completion
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err <= 1'b0;
        end else begin
            rsp_valid <= (done || abort) ? NUM_REQ'(1) << ptr : '0;
            rsp_rdata <= (done || abort) ? ((done && !write_q) ? apb.PRDATA : '0) : rsp_rdata;
            rsp_err <= (done || abort) ? (abort || apb.PSLVERR) : rsp_err;
        end
    end

    assign apb.PSEL = state != IDLE;
    assign apb.PENABLE = state == ACCESS;
    assign apb.PADDR = addr_q;
    assign apb.PWDATA = wdata_q;
    assign apb.PWRITE = write_q;
endmodule
